usr_irq_arbiter: RTL and testbench
==================================

// Module: usr_irq_arbiter
// PURPOSE
//  Collects NUM_SRC user interrupt lines and forwards each rising edge as a single Avalon-MM write to the interrupt mailbox register.
//  Pending edges are held sticky and served round-robin; one write is in flight at a time and waitrequest is honoured.
//  Sits between the HDMI/user logic interrupt sources and the Nios-facing irq Avalon master port.
// PARAMETERS
//  NUM_SRC      4      number of interrupt sources (2..16)
//  IRQ_ADDR     4'h0   word address of mailbox register driven on irq_avalon_master_address
//  WAIT_TIMEOUT 255    max cycles a write may stall on waitrequest before abort (1..255)
// PORTS
//  clk                            in   1        system clock
//  rst                            in   1        synchronous reset, active-high
//  usr_irq_in                     in   NUM_SRC  interrupt requests, synchronous to clk, rising-edge significant
//  irq_avalon_master_chipselect   out  1        Avalon chipselect
//  irq_avalon_master_address      out  4        Avalon address (always IRQ_ADDR while active)
//  irq_avalon_master_read         out  1        Avalon read (tied 0)
//  irq_avalon_master_write        out  1        Avalon write
//  irq_avalon_master_writedata    out  32       one-hot source mask: 1 << src index
//  irq_avalon_master_waitrequest  in   1        Avalon slave stall
//  irq_avalon_master_readdata     in   32       unused
//  irq_busy                       out  1        write in flight or any pending bit set
//  irq_drop_cnt                   out  8        saturating count of edges lost (source already pending)
//  irq_timeout                    out  1        sticky: a write aborted on timeout; cleared only by rst
// BEHAVIOUR
//  Reset (rst=1 at clk edge): all outputs 0, pending=0, edge regs=0, rr_ptr=0, FSM=IDLE, drop_cnt=0.
//  Edge detect: edge[i] = usr_irq_in[i] & ~usr_irq_d[i]; usr_irq_d cleared by rst, so a line high out of reset counts as an edge on the first cycle.
//  Pending: edge sets pending[i] next cycle. Edge on a bit already pending and not being cleared this cycle -> drop_cnt+1, saturate at 255.
//  Simultaneous set and clear of the same bit: set wins, bit stays pending, no drop counted.
//  Selection: round-robin starting at rr_ptr, first pending index upward with wrap; computed combinationally in IDLE.
//  FSM:
//   IDLE : if any pending -> latch sel; drive chipselect=1, write=1, address=IRQ_ADDR, writedata=1<<sel; go WRITE (outputs registered, visible the cycle after pending is seen).
//   WRITE: hold all outputs stable while waitrequest=1, incrementing wait_cnt.
//          waitrequest=0 -> transfer done: clear pending[sel], rr_ptr=(sel+1)%NUM_SRC, deassert chipselect/write, writedata=0, go GAP.
//          wait_cnt reaches WAIT_TIMEOUT with waitrequest still 1 -> deassert, set irq_timeout, pending[sel] kept, rr_ptr=(sel+1)%NUM_SRC, go GAP.
//   GAP  : one idle cycle (chipselect=0) between transfers, then IDLE.
//  Min latency edge->write asserted: 2 cycles; back-to-back writes separated by >=1 deasserted cycle.
//  Each accepted write is one cycle with waitrequest=0; writedata is never 0 while write=1.
//  irq_avalon_master_read constant 0; readdata ignored.
//  rst mid-transfer: outputs drop the next edge; all pending lost, no further writes until new edges.
// TESTING
//  Single edge on src2, waitrequest=0 -> exactly one write, address=IRQ_ADDR, writedata=32'h4, 1-cycle, 2 cycles after edge.
//  Edges on src0,src1,src3 same cycle, waitrequest=0 -> writes 32'h1, 32'h2, 32'h8 in order, each separated by 1 gap cycle; irq_busy low after last.
//  waitrequest held 5 cycles on src1 write -> chipselect/write/writedata=32'h2 stable 6 cycles, one transfer counted, no timeout.
//  waitrequest held high > WAIT_TIMEOUT=255 -> abort at 255 wait cycles, irq_timeout=1, src still pending, retried after other pending sources.
//  src0 toggles 3 times while first write stalled -> one further write for src0, irq_drop_cnt=1 (edge coinciding with clear not counted).
//  rst asserted in WRITE with 2 sources pending -> next cycle all outputs 0, irq_busy=0, drop_cnt=0, no writes after release.

Source files
------------

// File: rtl/usr_irq_arbiter.sv
// rtl/usr_irq_arbiter.sv - user interrupt edge collector and round-robin Avalon-MM mailbox writer
module usr_irq_arbiter #(
  parameter int         NUM_SRC      = 4,
  parameter logic [3:0] IRQ_ADDR     = 4'h0,
  parameter int         WAIT_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] usr_irq_in,
  output logic               irq_avalon_master_chipselect,
  output logic [3:0]         irq_avalon_master_address,
  output logic               irq_avalon_master_read,
  output logic               irq_avalon_master_write,
  output logic [31:0]        irq_avalon_master_writedata,
  input  logic               irq_avalon_master_waitrequest,
  input  logic [31:0]        irq_avalon_master_readdata,
  output logic               irq_busy,
  output logic [7:0]         irq_drop_cnt,
  output logic               irq_timeout
);

  localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [7:0]    WAIT_LAST = 8'(WAIT_TIMEOUT - 1);
  localparam logic [SW-1:0] LAST_IDX  = SW'(NUM_SRC - 1);
  localparam logic [SW:0]   NUM_SRC_W = (SW+1)'(NUM_SRC);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] usr_irq_d_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [SW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [SW-1:0]      sel_q, sel_d;
  logic [7:0]         wait_cnt_q, wait_cnt_d;
  logic               cs_q, cs_d;
  logic               wr_q, wr_d;
  logic [3:0]         addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [7:0]         drop_q, drop_d;
  logic               timeout_q, timeout_d;

  logic [NUM_SRC-1:0] rise_c;
  logic [NUM_SRC-1:0] clr_c;
  logic [NUM_SRC-1:0] drop_vec_c;
  logic [4:0]         drop_num_c;
  logic [8:0]         drop_sum_c;
  logic [SW-1:0]      sel_c;
  logic               found_c;
  logic [SW:0]        idx_sum_c;
  logic [SW-1:0]      idx_c;
  logic [SW-1:0]      next_ptr_c;
  logic               unused_readdata;

  // Avalon read side of this master is never used.
  assign unused_readdata = ^irq_avalon_master_readdata;

  assign rise_c     = usr_irq_in & ~usr_irq_d_q;
  assign next_ptr_c = (sel_q == LAST_IDX) ? '0 : sel_q + 1'b1;

  // Round-robin pick: first pending source at or above rr_ptr, wrapping.
  always_comb begin
    sel_c     = rr_ptr_q;
    found_c   = 1'b0;
    idx_sum_c = '0;
    idx_c     = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx_sum_c = {1'b0, rr_ptr_q} + (SW+1)'(k);
      if (idx_sum_c >= NUM_SRC_W) begin
        idx_sum_c = idx_sum_c - NUM_SRC_W;
      end
      idx_c = idx_sum_c[SW-1:0];
      if (!found_c && pending_q[idx_c]) begin
        found_c = 1'b1;
        sel_c   = idx_c;
      end
    end
  end

  // Transfer FSM: next state, registered bus outputs and pointer updates.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    rr_ptr_d   = rr_ptr_q;
    wait_cnt_d = wait_cnt_q;
    cs_d       = cs_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    timeout_d  = timeout_q;
    clr_c      = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (found_c) begin
          sel_d      = sel_c;
          cs_d       = 1'b1;
          wr_d       = 1'b1;
          addr_d     = IRQ_ADDR;
          wdata_d    = 32'd1 << sel_c;
          wait_cnt_d = '0;
          state_d    = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (!irq_avalon_master_waitrequest) begin
          clr_c    = {{(NUM_SRC-1){1'b0}}, 1'b1} << sel_q;
          cs_d     = 1'b0;
          wr_d     = 1'b0;
          addr_d   = '0;
          wdata_d  = '0;
          rr_ptr_d = next_ptr_c;
          state_d  = ST_GAP;
        end else if (wait_cnt_q == WAIT_LAST) begin
          // Abort: the source stays pending and is retried after the others.
          cs_d      = 1'b0;
          wr_d      = 1'b0;
          addr_d    = '0;
          wdata_d   = '0;
          timeout_d = 1'b1;
          rr_ptr_d  = next_ptr_c;
          state_d   = ST_GAP;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pending bits: a new edge wins over a same-cycle clear; edges on pending bits are drops.
  always_comb begin
    pending_d  = (pending_q & ~clr_c) | rise_c;
    drop_vec_c = rise_c & pending_q & ~clr_c;
    drop_num_c = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      drop_num_c = drop_num_c + {4'b0, drop_vec_c[k]};
    end
    drop_sum_c = {1'b0, drop_q} + {4'b0, drop_num_c};
    drop_d     = drop_sum_c[8] ? 8'hFF : drop_sum_c[7:0];
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      usr_irq_d_q <= '0;
      pending_q   <= '0;
      rr_ptr_q    <= '0;
      sel_q       <= '0;
      wait_cnt_q  <= '0;
      cs_q        <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      drop_q      <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      usr_irq_d_q <= usr_irq_in;
      pending_q   <= pending_d;
      rr_ptr_q    <= rr_ptr_d;
      sel_q       <= sel_d;
      wait_cnt_q  <= wait_cnt_d;
      cs_q        <= cs_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      drop_q      <= drop_d;
      timeout_q   <= timeout_d;
    end
  end

  assign irq_avalon_master_chipselect = cs_q;
  assign irq_avalon_master_address    = addr_q;
  assign irq_avalon_master_read       = 1'b0;
  assign irq_avalon_master_write      = wr_q;
  assign irq_avalon_master_writedata  = wdata_q;
  assign irq_busy                     = (state_q == ST_WRITE) | (|pending_q);
  assign irq_drop_cnt                 = drop_q;
  assign irq_timeout                  = timeout_q;

endmodule

// File: tb/tb_usr_irq_arbiter.sv
// tb/tb_usr_irq_arbiter.sv - scoreboard bench for usr_irq_arbiter
module tb_usr_irq_arbiter;

  localparam logic [3:0] ADDR = 4'hA;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  usr_irq_in = '0;
  logic        waitreq = 1'b0;
  logic [31:0] readdata = 32'hDEADBEEF;
  logic        cs, rd, wr, busy, tmo;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [7:0]  drop;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  usr_irq_arbiter #(
    .NUM_SRC(4),
    .IRQ_ADDR(ADDR),
    .WAIT_TIMEOUT(255)
  ) dut (
    .clk(clk),
    .rst(rst),
    .usr_irq_in(usr_irq_in),
    .irq_avalon_master_chipselect(cs),
    .irq_avalon_master_address(addr),
    .irq_avalon_master_read(rd),
    .irq_avalon_master_write(wr),
    .irq_avalon_master_writedata(wdata),
    .irq_avalon_master_waitrequest(waitreq),
    .irq_avalon_master_readdata(readdata),
    .irq_busy(busy),
    .irq_drop_cnt(drop),
    .irq_timeout(tmo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    usr_irq_in = '0;
    waitreq = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (!busy && !wr) break;
      tick();
    end
    chk("idle_reached", {31'b0, busy | wr}, 32'h0);
  endtask

  // Monitor: pops one expectation per accepted write and checks the bus gap.
  initial begin
    logic prev_acc;
    logic [31:0] e;
    prev_acc = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_acc = 1'b0;
      end else begin
        if (prev_acc) chk("gap_after_write", {31'b0, wr}, 32'h0);
        prev_acc = wr && !waitreq;
        if (wr && !waitreq) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got data %0h expected no write", wdata);
          end else begin
            e = exp_q.pop_front();
            chk("wdata", wdata, e);
            chk("address", {28'b0, addr}, {28'b0, ADDR});
            chk("chipselect", {31'b0, cs}, 32'h1);
            chk("read", {31'b0, rd}, 32'h0);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;

    // Reset state
    do_reset();
    chk("rst_cs", {31'b0, cs}, 0);
    chk("rst_wr", {31'b0, wr}, 0);
    chk("rst_addr", {28'b0, addr}, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_drop", {24'b0, drop}, 0);
    chk("rst_timeout", {31'b0, tmo}, 0);

    // Single edge on src2: write visible two cycles later, one cycle long
    exp_q.push_back(32'h4);
    usr_irq_in = 4'b0100;
    tick();
    chk("t1_wr_lat1", {31'b0, wr}, 0);
    chk("t1_busy", {31'b0, busy}, 1);
    tick();
    chk("t1_wr_lat2", {31'b0, wr}, 1);
    chk("t1_wdata", wdata, 32'h4);
    chk("t1_addr", {28'b0, addr}, {28'b0, ADDR});
    tick();
    chk("t1_wr_one_cycle", {31'b0, wr}, 0);
    usr_irq_in = '0;
    wait_idle(20);
    chk("t1_queue", exp_q.size(), 0);

    // Simultaneous edges on src0, src1, src3: round-robin order
    do_reset();
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h2);
    exp_q.push_back(32'h8);
    usr_irq_in = 4'b1011;
    tick();
    tick();
    usr_irq_in = '0;
    wait_idle(40);
    chk("t2_queue", exp_q.size(), 0);
    chk("t2_drop", {24'b0, drop}, 0);

    // Stall of 5 cycles on the src1 write
    do_reset();
    waitreq = 1'b1;
    exp_q.push_back(32'h2);
    usr_irq_in = 4'b0010;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (wr) begin
        cnt++;
        chk("t3_stable_wdata", wdata, 32'h2);
        chk("t3_stable_cs", {31'b0, cs}, 1);
        if (cnt == 6) begin
          waitreq = 1'b0;
          break;
        end
      end
    end
    chk("t3_write_cycles", cnt, 6);
    tick();
    chk("t3_wr_done", {31'b0, wr}, 0);
    usr_irq_in = '0;
    wait_idle(20);
    chk("t3_queue", exp_q.size(), 0);
    chk("t3_timeout", {31'b0, tmo}, 0);

    // Timeout on src1 with src2 also pending: abort, serve src2, retry src1
    do_reset();
    waitreq = 1'b1;
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h2);
    usr_irq_in = 4'b0110;
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (tmo) break;
      if (wr) cnt++;
    end
    chk("t4_stall_cycles", cnt, 255);
    chk("t4_timeout_set", {31'b0, tmo}, 1);
    chk("t4_wr_dropped", {31'b0, wr}, 0);
    chk("t4_busy_pending", {31'b0, busy}, 1);
    waitreq = 1'b0;
    usr_irq_in = '0;
    wait_idle(40);
    chk("t4_queue", exp_q.size(), 0);
    chk("t4_timeout_sticky", {31'b0, tmo}, 1);

    // src0 toggles during a stalled write; last edge coincides with the clear
    do_reset();
    waitreq = 1'b1;
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h1);
    usr_irq_in = 4'b0001;
    tick();
    usr_irq_in = 4'b0000;
    tick();
    chk("t5_wr_up", {31'b0, wr}, 1);
    usr_irq_in = 4'b0001;
    tick();
    chk("t5_drop_one", {24'b0, drop}, 1);
    usr_irq_in = 4'b0000;
    tick();
    usr_irq_in = 4'b0001;
    waitreq = 1'b0;
    tick();
    chk("t5_wr_accepted", {31'b0, wr}, 0);
    chk("t5_drop_no_coincide", {24'b0, drop}, 1);
    chk("t5_still_pending", {31'b0, busy}, 1);
    usr_irq_in = 4'b0000;
    wait_idle(20);
    chk("t5_queue", exp_q.size(), 0);
    chk("t5_drop_final", {24'b0, drop}, 1);

    // Reset in the middle of a stalled write with two sources pending
    do_reset();
    waitreq = 1'b1;
    usr_irq_in = 4'b0110;
    tick();
    usr_irq_in = 4'b0100;
    tick();
    usr_irq_in = 4'b0110;
    tick();
    chk("t6_wr_active", {31'b0, wr}, 1);
    chk("t6_drop_pre", {24'b0, drop}, 1);
    rst = 1'b1;
    usr_irq_in = '0;
    tick();
    chk("t6_cs", {31'b0, cs}, 0);
    chk("t6_wr", {31'b0, wr}, 0);
    chk("t6_wdata", wdata, 0);
    chk("t6_addr", {28'b0, addr}, 0);
    chk("t6_busy", {31'b0, busy}, 0);
    chk("t6_drop", {24'b0, drop}, 0);
    rst = 1'b0;
    waitreq = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t6_no_write", {31'b0, wr | cs}, 0);
    end
    chk("final_queue", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
